// File: rtl/vga_pkg.sv
// vga_pkg: shared FSM encoding and default timing/polarity constants
// for the framebuffer controller and its position tracker.
package vga_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int SYNC_ACTIVE_LOW = 0;
    typedef logic [1:0] state_t;
    localparam state_t WAIT_FRAME = 2'd0;
    localparam state_t BLANK = 2'd1;
    localparam state_t ACTIVE = 2'd2;
endpackage

// File: rtl/vga_pos_tracker.sv
// vga_pos_tracker: rebuilds the scan position from blank_n/v_sync and
// flags display reads that land outside the active frame.
module vga_pos_tracker
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W = 19,
    parameter int SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              v_sync,
    input  logic              px,
    input  logic              line_end,
    output logic [ADDR_W-1:0] x,
    output logic [ADDR_W-1:0] line_base,
    output logic              vs_edge,
    output logic              oob
);
    logic [ADDR_W-1:0] y;
    logic vs_act, vs_prev;

    assign vs_act = v_sync == (SYNC_POL != 0);
    assign vs_edge = vs_act && !vs_prev;
    assign oob = px && (x >= ADDR_W'(H_ACTIVE) || y >= ADDR_W'(V_ACTIVE));

    // vs_prev resets as if v_sync were already active, so only a fresh edge starts a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev <= 1'b1;
            x <= '0;
            y <= '0;
            line_base <= '0;
        end else begin
            vs_prev <= vs_act;
            if (vs_edge) begin
                x <= '0;
                y <= '0;
                line_base <= '0;
            end else begin
                x <= px ? x + ADDR_W'(1) : '0;
                if (line_end) begin
                    y <= y + ADDR_W'(1);
                    line_base <= line_base + ADDR_W'(H_ACTIVE);
                end
            end
        end
    end
endmodule

// File: rtl/vga_fb_controller.sv
// vga_fb_controller: shares a single-port framebuffer between VGA scan-out
// (active video) and a host writer (blanking), with a 2-cycle display pipe.
module vga_fb_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int PIXEL_W = 24,
    parameter int ADDR_W = 19,
    parameter int SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic               vga_clk_in,
    input  logic               reset_n_in,
    input  logic               blank_n_in,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    input  logic [ADDR_W-1:0]  host_addr_in,
    input  logic [PIXEL_W-1:0] host_data_in,
    input  logic               host_valid_in,
    output logic               host_ready_out,
    output logic [ADDR_W-1:0]  mem_addr_out,
    output logic               mem_we_out,
    output logic [PIXEL_W-1:0] mem_wdata_out,
    input  logic [PIXEL_W-1:0] mem_rdata_in,
    output logic [PIXEL_W-1:0] rgb_out,
    output logic               blank_n_out,
    output logic               h_sync_out,
    output logic               v_sync_out,
    output logic               frame_err_out
);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic SYNC_IDLE = (SYNC_POL == 0);

    state_t state, state_nxt;
    logic [ADDR_W-1:0] x, line_base;
    logic vs_edge, oob, px, line_end;
    logic blank_d, hs_d, vs_d, rd_d, err;

    vga_pos_tracker #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .ADDR_W(ADDR_W),
        .SYNC_POL(SYNC_POL)
    ) u_pos (
        .clk(vga_clk_in),
        .rst_n(reset_n_in),
        .v_sync(v_sync_in),
        .px(px),
        .line_end(line_end),
        .x(x),
        .line_base(line_base),
        .vs_edge(vs_edge),
        .oob(oob)
    );

    assign px = blank_n_in && state != WAIT_FRAME;
    assign line_end = state == ACTIVE && !blank_n_in;

    always_comb begin
        state_nxt = state == WAIT_FRAME ? (vs_edge ? BLANK : WAIT_FRAME)
                                        : (blank_n_in ? ACTIVE : BLANK);
    end

    // The display owns the RAM whenever blank_n is high; the host only gets blanking cycles
    assign host_ready_out = reset_n_in && !blank_n_in;
    assign mem_we_out = host_ready_out && host_valid_in;
    assign mem_addr_out = px ? (oob ? LAST_PIX : line_base + x)
                             : (mem_we_out ? host_addr_in : '0);
    assign mem_wdata_out = mem_we_out ? host_data_in : '0;
    assign frame_err_out = err;

    always_ff @(posedge vga_clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= WAIT_FRAME;
            blank_d <= 1'b0;
            blank_n_out <= 1'b0;
            hs_d <= SYNC_IDLE;
            h_sync_out <= SYNC_IDLE;
            vs_d <= SYNC_IDLE;
            v_sync_out <= SYNC_IDLE;
            rd_d <= 1'b0;
            rgb_out <= '0;
            err <= 1'b0;
        end else begin
            state <= state_nxt;
            blank_d <= blank_n_in;
            blank_n_out <= blank_d;
            hs_d <= h_sync_in;
            h_sync_out <= hs_d;
            vs_d <= v_sync_in;
            v_sync_out <= vs_d;
            rd_d <= px;
            rgb_out <= rd_d ? mem_rdata_in : '0;
            err <= err || oob;
        end
    end
endmodule

// File: tb/tb_vga_fb_controller.sv
// tb_vga_fb_controller: drives a small vga_sync-like timing into the controller
// with a preloaded RAM model (addr = data) and scoreboards the delayed outputs.
module tb_vga_fb_controller;
    localparam int H = 8;
    localparam int V = 4;
    localparam int PW = 24;
    localparam int AW = 19;

    typedef struct {
        logic b;
        logic h;
        logic v;
        logic [PW-1:0] rgb;
    } out_t;

    typedef struct {
        logic b;
        logic valid;
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
        logic ready;
        logic we;
        logic [AW-1:0] eaddr;
        logic [PW-1:0] ewdata;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, blank_n, hs, vs, host_valid;
    logic [AW-1:0] host_addr;
    logic [PW-1:0] host_data;
    logic host_ready, mem_we, blank_o, hs_o, vs_o, err;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_wdata, mem_rdata, rgb;

    vga_fb_controller #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .PIXEL_W(PW),
        .ADDR_W(AW),
        .SYNC_POL(0)
    ) dut (
        .vga_clk_in(clk),
        .reset_n_in(reset_n),
        .blank_n_in(blank_n),
        .h_sync_in(hs),
        .v_sync_in(vs),
        .host_addr_in(host_addr),
        .host_data_in(host_data),
        .host_valid_in(host_valid),
        .host_ready_out(host_ready),
        .mem_addr_out(mem_addr),
        .mem_we_out(mem_we),
        .mem_wdata_out(mem_wdata),
        .mem_rdata_in(mem_rdata),
        .rgb_out(rgb),
        .blank_n_out(blank_o),
        .h_sync_out(hs_o),
        .v_sync_out(vs_o),
        .frame_err_out(err)
    );

    logic [PW-1:0] ram [32];
    logic [PW-1:0] ref_mem [32];

    // RAM model: 1-cycle read latency, reloaded with addr = data while reset is held
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) ram[i] <= PW'(i);
        end else if (mem_we && mem_addr < 32) begin
            ram[mem_addr[4:0]] <= mem_wdata;
        end
        mem_rdata <= (mem_addr < 32) ? ram[mem_addr[4:0]] : '0;
    end

    int total = 0;
    int passed = 0;
    logic synced, vs_prev_tb, mon_en;
    logic [AW-1:0] exp_addr;
    out_t q[$];
    out_t rst_e = '{1'b0, 1'b1, 1'b1, 24'h0};
    vec_t tbl[6];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h want %0h", n, a, e);
    endtask

    function automatic int pix_addr(input int x, input int y);
        return (x >= H || y >= V) ? H * V - 1 : y * H + x;
    endfunction

    task automatic init_ref();
        for (int i = 0; i < 32; i++) ref_mem[i] = PW'(i);
        synced = 1'b0;
        vs_prev_tb = 1'b0;
    endtask

    task automatic drive(input logic b, input logic h, input logic v, input int x, input int y);
        blank_n = b;
        hs = h;
        vs = v;
        if (!v && vs_prev_tb) synced = 1'b1;
        vs_prev_tb = v;
        exp_addr = (b && synced) ? AW'(pix_addr(x, y)) : '0;
        q.push_back('{b, h, v, (b && synced) ? ref_mem[pix_addr(x, y)] : 24'h0});
    endtask

    task automatic cyc(input logic b, input logic h, input logic v, input int x, input int y);
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        drive(b, h, v, x, y);
    endtask

    // mode 1: host write of addr 9 in hblank; mode 2: host request held across the active line
    task automatic line(input int y, input int w, input int mode);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        host_valid = (mode == 1);
        host_addr = 19'd9;
        host_data = 24'hABCDEF;
        drive(0, 1, 1, 0, 0);
        #1;
        if (mode == 1) begin
            chk("hblank_ready", host_ready, 1);
            chk("hblank_we", mem_we, 1);
            chk("hblank_addr", mem_addr, 9);
            chk("hblank_wdata", mem_wdata, 24'hABCDEF);
            ref_mem[9] = 24'hABCDEF;
        end
        for (int x = 0; x < w; x++) begin
            @(posedge clk);
            #1;
            host_valid = (mode == 2);
            host_addr = 19'd20;
            host_data = 24'h123456;
            drive(1, 1, 1, x, y);
            #1;
            if (mode == 2) begin
                chk("held_ready", host_ready, 0);
                chk("held_we", mem_we, 0);
            end
        end
        if (mode == 2) begin
            @(posedge clk);
            #1;
            drive(0, 1, 1, 0, 0);
            #1;
            chk("held_accept_we", mem_we, 1);
            chk("held_accept_addr", mem_addr, 20);
            chk("held_accept_wdata", mem_wdata, 24'h123456);
            ref_mem[20] = 24'h123456;
        end
    endtask

    task automatic frame_head();
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) cyc(0, 1, 1, 0, 0);
    endtask

    task automatic frame(input int w, input int hl, input int mode);
        frame_head();
        for (int l = 0; l < V; l++) line(l, w, l == hl ? mode : 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rgb"}, rgb, 0);
        chk({tag, "_blank_out"}, blank_o, 0);
        chk({tag, "_hsync_out"}, hs_o, 1);
        chk({tag, "_vsync_out"}, vs_o, 1);
        chk({tag, "_frame_err"}, err, 0);
        chk({tag, "_ready"}, host_ready, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        q.delete();
        q.push_back(rst_e);
        q.push_back(rst_e);
        host_valid = 1'b0;
        drive(0, 1, 1, 0, 0);
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        out_t e;
        if (mon_en && blank_n) chk("read_addr", mem_addr, exp_addr);
        if (mon_en && q.size() >= 3) begin
            e = q.pop_front();
            chk("rgb", rgb, e.rgb);
            chk("blank_out", blank_o, e.b);
            chk("hsync_out", hs_o, e.h);
            chk("vsync_out", vs_o, e.v);
        end
    end

    initial begin
        tbl[0] = '{1'b0, 1'b0, 19'd5, 24'h111111, 1'b1, 1'b0, 19'd0, 24'h0};
        tbl[1] = '{1'b0, 1'b1, 19'd5, 24'h111111, 1'b1, 1'b1, 19'd5, 24'h111111};
        tbl[2] = '{1'b1, 1'b1, 19'd6, 24'h222222, 1'b0, 1'b0, 19'd0, 24'h0};
        tbl[3] = '{1'b0, 1'b1, 19'd40, 24'h333333, 1'b1, 1'b1, 19'd40, 24'h333333};
        tbl[4] = '{1'b0, 1'b1, 19'd5, 24'h000005, 1'b1, 1'b1, 19'd5, 24'h000005};
        tbl[5] = '{1'b1, 1'b0, 19'd0, 24'h0, 1'b0, 1'b0, 19'd0, 24'h0};
        mon_en = 1'b0;
        reset_n = 1'b0;
        blank_n = 1'b0;
        hs = 1'b1;
        vs = 1'b1;
        host_valid = 1'b0;
        host_addr = '0;
        host_data = '0;
        exp_addr = '0;
        init_ref();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        release_reset();
        // host-port vectors while still waiting for the first frame
        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            host_valid = tbl[i].valid;
            host_addr = tbl[i].addr;
            host_data = tbl[i].data;
            drive(tbl[i].b, 1, 1, 0, 0);
            #1;
            chk("vec_ready", host_ready, tbl[i].ready);
            chk("vec_we", mem_we, tbl[i].we);
            chk("vec_addr", mem_addr, tbl[i].eaddr);
            chk("vec_wdata", mem_wdata, tbl[i].ewdata);
            if (tbl[i].we && tbl[i].addr < 32) ref_mem[tbl[i].addr[4:0]] = tbl[i].data;
        end
        line(0, H, 0);
        line(1, H, 0);
        frame(H, -1, 0);
        chk("frame_err_clean", err, 0);
        frame(H, 2, 1);
        frame(H, 1, 2);
        chk("frame_err_clean2", err, 0);
        frame(H + 2, -1, 0);
        chk("frame_err_wide", err, 1);
        frame(H, -1, 0);
        chk("frame_err_sticky", err, 1);
        frame_head();
        line(0, H, 0);
        line(1, H, 0);
        line(2, 3, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        mon_en = 1'b0;
        q.delete();
        #1;
        reset_checks("midline");
        blank_n = 1'b0;
        repeat (3) @(posedge clk);
        init_ref();
        release_reset();
        line(0, H, 0);
        frame(H, -1, 0);
        chk("frame_err_after_reset", err, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
